// File: rtl/shape_pkg.sv
// Shared definitions for the shape record writer and reader: field word
// indices, the read-tag format and the reader state encoding.
package shape_pkg;

    localparam int NFIELD = 5;

    typedef logic [2:0] field_idx_t;

    localparam field_idx_t F_TY     = 3'd0;
    localparam field_idx_t F_X      = 3'd1;
    localparam field_idx_t F_Y      = 3'd2;
    localparam field_idx_t F_SIZE   = 3'd3;
    localparam field_idx_t F_ROTATE = 3'd4;

    // One in-flight RAM read: which field register the returning word belongs to.
    typedef struct packed {
        logic       valid;
        field_idx_t idx;
    } tag_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/shape_read_if.sv
// Read port of the shape RAM: the reader drives address/enable, the RAM
// returns data a fixed number of cycles later.
interface shape_read_if #(
    parameter int ADDRW = 20,
    parameter int DATAW = 12
);
    logic [ADDRW-1:0] ram_address;
    logic             ram_enable;
    logic [DATAW-1:0] ram_data;

    modport master (output ram_address, output ram_enable, input ram_data);
    modport slave  (input ram_address, input ram_enable, output ram_data);
endinterface

// File: rtl/shape_read_tag_pipe.sv
// Delays a read tag by exactly the RAM read latency so it lines up with the
// returning data word.
module shape_read_tag_pipe
    import shape_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every stage is cleared so reads in flight at reset can never land in a field.
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/shape_read.sv
// Reads the five words of one shape record from shape RAM and presents them
// as registered fields, pulsing done once the whole record has arrived.
module shape_read
    import shape_pkg::*;
#(
    parameter int DATAB    = 3,
    parameter int CORDW    = 10,
    parameter int ADDRW    = 20,
    parameter int DATAW    = 12,
    parameter int NUMW     = DATAW,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUMW-1:0]   id,
    input  logic              trigger,
    input  logic [ADDRW-1:0]  ram_address_offset,
    shape_read_if.master      ram,
    output logic              busy,
    output logic              done,
    output logic [DATAW-1:0]  ty,
    output logic [CORDW-1:0]  x,
    output logic [CORDW-1:0]  y,
    output logic [DATAW-1:0]  size,
    output logic [DATAW-1:0]  rotate
);

    state_t           state, state_next;
    field_idx_t       ptr, ptr_next;
    logic [ADDRW-1:0] base_q, base_next;
    logic [ADDRW-1:0] addr_next;
    logic             en_next;
    logic             done_next;
    tag_t             tag_out;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        ptr_next   = ptr;
        base_next  = base_q;
        addr_next  = ram.ram_address;
        en_next    = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_next = S_ISSUE;
                    ptr_next   = F_TY;
                    base_next  = (ADDRW'(id) << DATAB) + ram_address_offset;
                    addr_next  = base_next;
                    en_next    = 1'b1;
                end
            end
            S_ISSUE: begin
                if (ptr == F_ROTATE) begin
                    state_next = S_DRAIN;
                end else begin
                    ptr_next  = ptr + 1'b1;
                    addr_next = base_q + ADDRW'(ptr_next);
                    en_next   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (tag_out.valid && tag_out.idx == F_ROTATE) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state and registered outputs use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            ptr             <= F_TY;
            base_q          <= '0;
            ram.ram_address <= '0;
            ram.ram_enable  <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_next;
            ptr             <= ptr_next;
            base_q          <= base_next;
            ram.ram_address <= addr_next;
            ram.ram_enable  <= en_next;
            done            <= done_next;
        end
    end

    assign busy = (state != S_IDLE);

    // ptr names the word whose address is on the bus this cycle.
    shape_read_tag_pipe #(.DEPTH(READ_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  ('{valid: ram.ram_enable, idx: ptr}),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ty     <= '0;
            x      <= '0;
            y      <= '0;
            size   <= '0;
            rotate <= '0;
        end else if (tag_out.valid) begin
            case (tag_out.idx)
                F_TY:     ty     <= ram.ram_data;
                F_X:      x      <= ram.ram_data[CORDW-1:0];
                F_Y:      y      <= ram.ram_data[CORDW-1:0];
                F_SIZE:   size   <= ram.ram_data;
                F_ROTATE: rotate <= ram.ram_data;
                default:  ;
            endcase
        end
    end

endmodule

// File: doc/shape_read.md
# shape_read

Reads one shape record from shape RAM and presents its fields in parallel to the renderer and game logic. Records use the layout the shape writer produces: 2^DATAB words per shape at `(id << DATAB) + ram_address_offset`, words 0..4 holding ty, x, y, size and rotate. The block issues five read addresses, realigns the RAM's fixed read latency, registers each field, and pulses `done` when the full record is valid.

## Interface
Parameters:
- DATAB, 3, log2 of words per record (8)
- CORDW, 10, coordinate width
- ADDRW, 20, RAM address width
- DATAW, 12, RAM data width
- NUMW, DATAW, shape id width
- READ_LAT, 1, RAM read latency in cycles (address to data), ≥1

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- id  in  NUMW  shape index, sampled on trigger
- trigger  in  1  start a record read; ignored while busy
- ram_address_offset  in  ADDRW  base of shape region, sampled on trigger
- ram_address  out  ADDRW  read address
- ram_enable  out  1  read enable
- ram_data  in  DATAW  read data, valid READ_LAT cycles after address/enable
- busy  out  1  read in progress
- done  out  1  one-cycle pulse, all fields valid
- ty, size, rotate  out  DATAW each  record words 0, 3, 4
- x, y  out  CORDW each  low CORDW bits of words 1, 2

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: trigger=1 latches id and offset, clears ptr, goes to ISSUE.
- ISSUE: ram_enable=1, ram_address = (id_q << DATAB) + offset_q + ptr, ptr 0..4; after ptr=4 goes to DRAIN. Words 5..7 never read.
- Per issued read, a tag (valid, field index) enters a READ_LAT-deep shift register; at the output, ram_data is written into the indexed field register.
- DRAIN: waits until the tag for field 4 emerges and is captured, then returns to IDLE with done=1 for one cycle.
- Address arithmetic modulo 2^ADDRW; id zero-extended before shifting; wrap is not an error.
- x/y take ram_data[CORDW-1:0]; upper bits discarded.
- Field outputs hold their value from done until individually overwritten by the next read; consumers sample only on done.
- trigger while busy: ignored, no queueing. trigger in the done cycle: accepted (busy is already low).
- Reset values: state IDLE, ram_enable 0, ram_address 0, busy 0, done 0, all fields 0, tag pipe cleared.
- rst mid-operation: abort on that edge, no done, in-flight RAM returns discarded, fields reset to 0.

## Timing
- Cycle 0: trigger sampled high.
- Cycles 1..5: ram_enable=1, ptr 0..4.
- Field p captured at end of cycle 1+p+READ_LAT.
- done=1 in cycle 6+READ_LAT, fields valid same cycle; busy=1 in cycles 1..5+READ_LAT.
- Trigger-to-done latency 6+READ_LAT (7 at default); back-to-back throughput one record per 6+READ_LAT cycles.
- ram_enable and ram_address registered; field outputs and done registered.

## Structure
- Shared package `shape_pkg`: field index constants (F_TY=0, F_X=1, F_Y=2, F_SIZE=3, F_ROTATE=4), NFIELD=5, state enum; used by writer and reader.
- Sub-module `shape_read_tag_pipe`: parameterized READ_LAT-deep shift register of {valid, index}, synchronous reset clear.

## Test plan
- Model RAM with READ_LAT=1 holding id 3, offset 0x100 at 0x118..0x11C = {0x005, 0x140, 0x0F0, 0x020, 0x0B4}; trigger id=3 -> addresses 0x118..0x11C in cycles 1..5, done in cycle 7, ty=5, x=320, y=240, size=32, rotate=180.
- Word 1 = 0xD40 -> x=0x140 (upper bits dropped).
- READ_LAT=3, same record -> done in cycle 9, identical fields, busy high cycles 1..8.
- trigger held high throughout -> second read starts cycle after done only; no extra done; pulse at cycle 3 during first read ignored.
- rst in cycle 4 -> ram_enable 0 and busy 0 next cycle, no done, fields 0; new trigger then completes normally.
- id=0xFFF, offset=0xFFFF8 at ADDRW=20 -> addresses wrap modulo 2^20 starting at 0x07FF0, done asserted normally.
